// File: rtl/fp_mag_compare_seq_pkg.sv
// Shared definitions for the magnitude-ordering controller: state encoding,
// slice geometry helpers and the operand/slice width legality check.
package fp_mag_compare_seq_pkg;

  localparam int W_DEF  = 32;
  localparam int CW_DEF = 8;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COMPARE = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    COMPARE = ST_COMPARE,
    DONE    = ST_DONE
  } state_e;

  function automatic int num_slices(input int w, input int cw);
    return w / cw;
  endfunction

  // A single-slice configuration still needs a one-bit index register.
  function automatic int idx_width(input int w, input int cw);
    return ((w / cw) > 1) ? $clog2(w / cw) : 1;
  endfunction

  function automatic bit cfg_ok(input int w, input int cw);
    return (cw > 0) && (w >= cw) && ((w % cw) == 0);
  endfunction

endpackage

// File: rtl/fp_mag_compare_seq_if.sv
// Operand-pair request and ordered-result response bundle between the
// FP add/sub front end and the magnitude-ordering controller.
interface fp_mag_compare_seq_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] Data_X;
  logic [W-1:0] Data_Y;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] DMP;
  logic [W-1:0] DmP;
  logic         swap;
  logic         eq_mag;

  modport master (
    output in_valid, Data_X, Data_Y, out_ready,
    input  in_ready, out_valid, DMP, DmP, swap, eq_mag
  );

  modport slave (
    input  in_valid, Data_X, Data_Y, out_ready,
    output in_ready, out_valid, DMP, DmP, swap, eq_mag
  );
endinterface

// File: rtl/fp_mag_compare_seq_comparator_less.sv
// Unsigned less-than comparator used on one operand slice per cycle.
module Comparator_Less #(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         lt_o
);

  assign lt_o = (a_i < b_i);

endmodule

// File: rtl/fp_mag_compare_seq.sv
// Ranks an operand pair by magnitude using one slice comparison per cycle,
// most-significant slice first, stopping at the first slice that differs.
module fp_mag_compare_seq
  import fp_mag_compare_seq_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int CW = CW_DEF
) (
  input logic                  clk,
  input logic                  rst,
  fp_mag_compare_seq_if.slave  bus
);

  localparam int N  = num_slices(W, CW);
  localparam int IW = idx_width(W, CW);
  localparam logic [IW-1:0] IDX_TOP = IW'(N - 1);

  generate
    if (!cfg_ok(W, CW)) begin : g_cfg_err
      $error("fp_mag_compare_seq: W must be a non-zero multiple of CW");
    end
  endgenerate

  state_e        state_q, state_d;
  logic [W-1:0]  x_q, x_d, y_q, y_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          rv_q, rv_d;
  logic          lt_q, lt_d, gt_q, gt_d, last_q, last_d;
  logic          swap_q, swap_d, eq_q, eq_d;
  logic [W-1:0]  dmp_q, dmp_d, dmn_q, dmn_d;

  logic [W-1:0]  x_mag, y_mag;
  logic [CW-1:0] sx, sy;
  logic          lt_s, gt_s;

  assign x_mag = {1'b0, x_q[W-2:0]};
  assign y_mag = {1'b0, y_q[W-2:0]};
  assign sx    = x_mag[int'(idx_q)*CW +: CW];
  assign sy    = y_mag[int'(idx_q)*CW +: CW];

  // Two comparator instances evaluate both orderings of the slice in one cycle.
  Comparator_Less #(.W(CW)) u_lt (.a_i(sx), .b_i(sy), .lt_o(lt_s));
  Comparator_Less #(.W(CW)) u_gt (.a_i(sy), .b_i(sx), .lt_o(gt_s));

  // State, operand, slice-result and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      idx_q   <= IDX_TOP;
      rv_q    <= 1'b0;
      lt_q    <= 1'b0;
      gt_q    <= 1'b0;
      last_q  <= 1'b0;
      swap_q  <= 1'b0;
      eq_q    <= 1'b0;
      dmp_q   <= '0;
      dmn_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      idx_q   <= idx_d;
      rv_q    <= rv_d;
      lt_q    <= lt_d;
      gt_q    <= gt_d;
      last_q  <= last_d;
      swap_q  <= swap_d;
      eq_q    <= eq_d;
      dmp_q   <= dmp_d;
      dmn_q   <= dmn_d;
    end
  end

  // Next-state logic; each slice result is registered and acted on the
  // following cycle, while the next slice is already being compared.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    idx_d   = idx_q;
    rv_d    = rv_q;
    lt_d    = lt_q;
    gt_d    = gt_q;
    last_d  = last_q;
    swap_d  = swap_q;
    eq_d    = eq_q;
    dmp_d   = dmp_q;
    dmn_d   = dmn_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          x_d     = bus.Data_X;
          y_d     = bus.Data_Y;
          idx_d   = IDX_TOP;
          rv_d    = 1'b0;
          state_d = COMPARE;
        end else begin
          state_d = IDLE;
        end
      end
      COMPARE: begin
        if (rv_q && (lt_q || gt_q || last_q)) begin
          state_d = DONE;
          swap_d  = lt_q;
          eq_d    = !(lt_q || gt_q);
          dmp_d   = lt_q ? y_q : x_q;
          dmn_d   = lt_q ? x_q : y_q;
        end else begin
          rv_d   = 1'b1;
          lt_d   = lt_s;
          gt_d   = gt_s;
          last_d = (idx_q == '0);
          if (idx_q != '0) begin
            idx_d = idx_q - 1'b1;
          end else begin
            idx_d = idx_q;
          end
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.DMP       = dmp_q;
  assign bus.DmP       = dmn_q;
  assign bus.swap      = swap_q;
  assign bus.eq_mag    = eq_q;

endmodule

// File: tb/tb_fp_mag_compare_seq.sv
// Scoreboard bench for fp_mag_compare_seq: a driver pushes reference-model
// expectations, a negedge monitor pops and checks each delivered result.
module tb_fp_mag_compare_seq;

  localparam int W  = 32;
  localparam int CW = 8;
  localparam int N  = W / CW;

  typedef struct {
    logic [31:0] dmp;
    logic [31:0] dmn;
    logic        swap;
    logic        eq;
    int          lat;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   rdy_mode = 0;
  logic man_rdy = 1'b0;
  exp_t sb_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fp_mag_compare_seq_if #(.W(W)) bus ();

  fp_mag_compare_seq #(.W(W), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: magnitudes as plain integers, latency from first differing byte.
  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input int acc);
    exp_t e;
    logic [31:0] mx, my;
    bit found;
    mx = x & 32'h7FFF_FFFF;
    my = y & 32'h7FFF_FFFF;
    e.swap = (mx < my);
    e.eq   = (mx == my);
    e.dmp  = e.swap ? y : x;
    e.dmn  = e.swap ? x : y;
    e.acc  = acc;
    e.lat  = N + 1;
    found  = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!found && (((mx >> (CW * i)) & 32'hFF) != ((my >> (CW * i)) & 32'hFF))) begin
        e.lat = N - i + 1;
        found = 1'b1;
      end
    end
    return e;
  endfunction

  always @(posedge clk) begin
    #1;
    if (rdy_mode == 1) bus.out_ready = 1'($urandom_range(0, 1));
    else if (rdy_mode == 2) bus.out_ready = man_rdy;
    else bus.out_ready = 1'b1;
  end

  logic        prev_v = 1'b0;
  logic [31:0] h_dmp, h_dmn;
  logic        h_sw, h_eq;

  always @(negedge clk) begin
    if (rst) begin
      prev_v = 1'b0;
    end else if (bus.out_valid) begin
      chk("in_ready_low_while_valid", 32'(bus.in_ready), 32'd0);
      if (!prev_v) begin
        if (sb_q.size() == 0) chk("unexpected_result", 32'd1, 32'd0);
        else chk("latency", 32'(cyc - sb_q[0].acc), 32'(sb_q[0].lat));
      end else begin
        chk("hold_DMP", bus.DMP, h_dmp);
        chk("hold_DmP", bus.DmP, h_dmn);
        chk("hold_swap", 32'(bus.swap), 32'(h_sw));
        chk("hold_eq", 32'(bus.eq_mag), 32'(h_eq));
      end
      h_dmp = bus.DMP; h_dmn = bus.DmP; h_sw = bus.swap; h_eq = bus.eq_mag;
      if (bus.out_ready) begin
        if (sb_q.size() != 0) begin
          exp_t e;
          e = sb_q.pop_front();
          chk("DMP", bus.DMP, e.dmp);
          chk("DmP", bus.DmP, e.dmn);
          chk("swap", 32'(bus.swap), 32'(e.swap));
          chk("eq_mag", 32'(bus.eq_mag), 32'(e.eq));
        end
        prev_v = 1'b0;
      end else begin
        prev_v = 1'b1;
      end
    end else begin
      prev_v = 1'b0;
    end
  end

  // Called at posedge+1; returns at posedge+1 of the accept edge.
  task automatic send(input logic [31:0] x, input logic [31:0] y);
    int b = 0;
    while (!bus.in_ready && b < 100) begin
      @(posedge clk); #1; b++;
    end
    if (!bus.in_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
    end else begin
      bus.in_valid = 1'b1;
      bus.Data_X   = x;
      bus.Data_Y   = y;
      @(posedge clk); #1;
      sb_q.push_back(model(x, y, cyc));
      bus.in_valid = 1'b0;
      bus.Data_X   = $urandom;
      bus.Data_Y   = $urandom;
    end
  endtask

  task automatic drain();
    int b = 0;
    while ((sb_q.size() != 0 || !bus.in_ready) && b < 200) begin
      @(posedge clk); #1; b++;
    end
    if (b >= 200) begin
      chk("drain_timeout", 32'd0, 32'd1);
      sb_q.delete();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    logic [31:0] x, y;
    bus.in_valid = 1'b0;
    bus.Data_X   = 32'h0;
    bus.Data_Y   = 32'h0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_DMP", bus.DMP, 32'h0);
    chk("rst_DmP", bus.DmP, 32'h0);
    chk("rst_swap", 32'(bus.swap), 32'd0);
    chk("rst_eq", 32'(bus.eq_mag), 32'd0);
    @(posedge clk); #1;

    send(32'h4000_0000, 32'h3F80_0000); drain();
    send(32'h3F80_0000, 32'hC000_0000); drain();
    send(32'h3F80_0001, 32'h3F80_0002); drain();
    send(32'h3F80_0000, 32'hBF80_0000); drain();
    send(32'h0000_0000, 32'h8000_0000); drain();

    // Downstream stall in DONE, then back-to-back accept.
    rdy_mode = 2; man_rdy = 1'b0;
    @(posedge clk); #1;
    send(32'h3F80_0000, 32'h4000_0000);
    b = 0;
    while (!bus.out_valid && b < 50) begin @(posedge clk); #1; b++; end
    chk("stall_valid_seen", 32'(bus.out_valid), 32'd1);
    repeat (3) @(posedge clk);
    @(negedge clk); man_rdy = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    chk("in_ready_after_handshake", 32'(bus.in_ready), 32'd1);
    chk("valid_drop_after_handshake", 32'(bus.out_valid), 32'd0);
    rdy_mode = 0;
    send(32'hC120_0000, 32'h4120_0001); drain();

    // Reset in the second COMPARE cycle aborts the operation.
    send(32'h3F80_0001, 32'h3F80_0002);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    sb_q.delete();
    @(negedge clk);
    chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
    chk("abort_DMP", bus.DMP, 32'h0);
    @(posedge clk); #1;
    send(32'h0000_0001, 32'h0000_0000); drain();

    // Randomized pairs with random downstream back-pressure.
    rdy_mode = 1;
    for (int i = 0; i < 60; i++) begin
      x = $urandom;
      case ($urandom_range(0, 3))
        0: y = $urandom;
        1: y = x ^ 32'h8000_0000;
        2: y = x ^ (32'h1 << $urandom_range(0, 30));
        default: y = x;
      endcase
      send(x, y);
    end
    drain();
    rdy_mode = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
